// File: rtl/alu_seq_unit.sv
// Handshaked ALU with a registered accumulator and a shift-add unsigned multiply.
// Single-cycle ops complete in one cycle; MUL takes W steps before DONE.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for a request; in_ready=1
// MUL   | one shift-add partial-product step per cycle; busy=1
// DONE  | result/flags valid; held until the consumer takes them
module alu_seq_unit #(
  parameter int W    = 4,
  parameter int CNTW = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [2:0]   op,
  input  logic         use_acc,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic         cout,
  output logic         overflow,
  output logic         zero,
  output logic         busy
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SLT = 3'b101;
  localparam logic [2:0] OP_MUL = 3'b110;

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

  state_t          state, state_nxt;
  logic            accept, handoff, mul_last;
  logic [W-1:0]    acc, opa;
  logic [2*W-1:0]  mcand, prod, prod_step;
  logic [W-1:0]    mplier;
  logic [CNTW-1:0] cnt;
  logic [W-1:0]    alu_res;
  logic            alu_c, alu_v;
  logic [W:0]      sum;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    accept    = 1'b0;
    handoff   = 1'b0;
    mul_last  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept    = 1'b1;
          state_nxt = (op == OP_MUL) ? MUL : DONE;
        end
      end
      MUL: begin
        busy = 1'b1;
        if (cnt == CNTW'(W - 1)) begin
          mul_last  = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          handoff   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign opa = use_acc ? acc : a;

  always_comb begin
    sum     = '0;
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (op)
      OP_ADD: begin
        sum     = {1'b0, opa} + {1'b0, b};
        alu_res = sum[W-1:0];
        alu_c   = sum[W];
        alu_v   = (opa[W-1] == b[W-1]) && (sum[W-1] != opa[W-1]);
      end
      OP_SUB: begin
        sum     = {1'b0, opa} + {1'b0, ~b} + (W+1)'(1);
        alu_res = sum[W-1:0];
        alu_c   = sum[W];
        alu_v   = (opa[W-1] != b[W-1]) && (sum[W-1] != opa[W-1]);
      end
      OP_AND:  alu_res = opa & b;
      OP_OR:   alu_res = opa | b;
      OP_XOR:  alu_res = opa ^ b;
      OP_SLT:  alu_res = {{(W-1){1'b0}}, ($signed(opa) < $signed(b))};
      default: alu_res = '0;
    endcase
  end

  // multiplicand shifts left and multiplier right, so each step only looks at mplier[0]
  assign prod_step = prod + (mplier[0] ? mcand : '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      acc      <= '0;
      result   <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
      zero     <= 1'b0;
      mcand    <= '0;
      mplier   <= '0;
      prod     <= '0;
      cnt      <= '0;
    end else begin
      if (accept) begin
        if (op == OP_MUL) begin
          mcand  <= {{W{1'b0}}, opa};
          mplier <= b;
          prod   <= '0;
          cnt    <= '0;
        end else begin
          result   <= alu_res;
          cout     <= alu_c;
          overflow <= alu_v;
          zero     <= (alu_res == '0);
        end
      end
      if (state == MUL) begin
        prod   <= prod_step;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt + CNTW'(1);
        if (mul_last) begin
          result   <= prod_step[W-1:0];
          cout     <= |prod_step[2*W-1:W];
          overflow <= |prod_step[2*W-1:W];
          zero     <= (prod_step[W-1:0] == '0);
        end
      end
      // acc only ever takes a result the consumer has actually taken
      if (handoff) acc <= result;
    end
  end

endmodule

// File: tb/tb_alu_seq_unit.sv
// Bench for alu_seq_unit: directed literal cases plus randomized traffic,
// all checked every cycle against a transaction-level reference model.
module tb_alu_seq_unit;
  localparam int W    = 4;
  localparam int CNTW = 3;
  localparam int FULL = 1 << W;
  localparam int HALF = 1 << (W - 1);

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [2:0]   op = '0;
  logic         use_acc = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] result;
  logic         cout, overflow, zero, busy;

  int n_chk  = 0;
  int n_fail = 0;

  alu_seq_unit #(.W(W), .CNTW(CNTW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .use_acc(use_acc),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .cout(cout), .overflow(overflow), .zero(zero),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int sgn(input int x);
    return (x >= HALF) ? x - FULL : x;
  endfunction

  // Reference: plain integer arithmetic over the opcode definitions
  function automatic void ref_op(input int o, input int x, input int y,
                                 output int r, output int c, output int v);
    int s;
    r = 0; c = 0; v = 0;
    case (o)
      0: begin s = x + y; r = s % FULL; c = s / FULL;
               v = int'((sgn(x) + sgn(y) > HALF - 1) || (sgn(x) + sgn(y) < -HALF)); end
      1: begin r = (x - y + FULL) % FULL; c = int'(x >= y);
               v = int'((sgn(x) - sgn(y) > HALF - 1) || (sgn(x) - sgn(y) < -HALF)); end
      2: r = x & y;
      3: r = x | y;
      4: r = x ^ y;
      5: r = int'(sgn(x) < sgn(y));
      6: begin s = x * y; r = s % FULL; c = int'(s >= FULL); v = c; end
      default: r = 0;
    endcase
  endfunction

  // Model state: one outstanding transaction at most
  bit chk_en  = 1'b0;
  bit pend    = 1'b0;
  bit m_fresh = 1'b0;
  int m_acc = 0, age = 0, lat = 0;
  int e_res = 0, e_c = 0, e_v = 0;

  always @(posedge clk) begin
    int opa;
    if (rst) begin
      pend = 1'b0; m_acc = 0; m_fresh = 1'b1; chk_en = 1'b1;
    end else if (pend) begin
      if (age >= lat && out_ready) begin
        m_acc = e_res;
        pend  = 1'b0;
      end else age++;
    end else if (in_valid) begin
      opa = use_acc ? m_acc : int'(a);
      ref_op(int'(op), opa, int'(b), e_res, e_c, e_v);
      lat = (op == 3'd6) ? W : 0;
      age = 0;
      pend = 1'b1;
      m_fresh = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      if (!pend) begin
        chk("idle_in_ready", in_ready, 1);
        chk("idle_out_valid", out_valid, 0);
        chk("idle_busy", busy, 0);
        if (m_fresh) begin
          chk("reset_result", result, 0);
          chk("reset_cout", cout, 0);
          chk("reset_overflow", overflow, 0);
          chk("reset_zero", zero, 0);
        end
      end else if (age < lat) begin
        chk("mul_in_ready", in_ready, 0);
        chk("mul_out_valid", out_valid, 0);
        chk("mul_busy", busy, 1);
      end else begin
        chk("done_in_ready", in_ready, 0);
        chk("done_out_valid", out_valid, 1);
        chk("done_busy", busy, 0);
        chk("done_result", result, e_res);
        chk("done_cout", cout, e_c);
        chk("done_overflow", overflow, e_v);
        chk("done_zero", zero, int'(e_res == 0));
      end
    end
  end

  // Issue one request from a negedge, hold the result for 'hold' cycles, then take it
  task automatic run_op(input int ia, input int ib, input int iop, input int iu, input int hold,
                        output int r, output int c, output int v, output int z, output int l);
    int k;
    r = 0; c = 0; v = 0; z = 0;
    a = W'(ia); b = W'(ib); op = 3'(iop); use_acc = iu[0];
    in_valid = 1'b1; out_ready = 1'b0;
    k = 0;
    while (!in_ready && k < 50) begin @(negedge clk); k++; end
    chk("accept_wait", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    a = W'($urandom); b = W'($urandom); op = 3'($urandom); use_acc = 1'($urandom);
    l = 1;
    while (!out_valid && l < 50) begin @(negedge clk); l++; end
    chk("result_wait", out_valid, 1);
    repeat (hold) @(negedge clk);
    r = int'(result); c = int'(cout); v = int'(overflow); z = int'(zero);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("in_ready_after_handoff", in_ready, 1);
  endtask

  initial begin
    int r, c, v, z, l;

    ref_op(0, 9, 10, r, c, v);
    chk("model_add", r * 4 + c * 2 + v, 3 * 4 + 2 + 1);
    ref_op(1, 3, 15, r, c, v);
    chk("model_sub", r * 4 + c * 2 + v, 4 * 4);
    ref_op(6, 12, 8, r, c, v);
    chk("model_mul", r * 4 + c * 2 + v, 3);
    ref_op(5, 8, 7, r, c, v);
    chk("model_slt", r, 1);

    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    run_op(4'b1001, 4'b1010, 0, 0, 0, r, c, v, z, l);
    chk("t1_result", r, 4'b0011); chk("t1_cout", c, 1); chk("t1_ovf", v, 1);
    chk("t1_zero", z, 0); chk("t1_latency", l, 1);

    run_op(4'b0011, 4'b1111, 1, 0, 0, r, c, v, z, l);
    chk("t2_result", r, 4'b0100); chk("t2_cout", c, 0); chk("t2_ovf", v, 0); chk("t2_zero", z, 0);

    run_op(4'b1100, 4'b1000, 6, 0, 0, r, c, v, z, l);
    chk("t3_result", r, 0); chk("t3_cout", c, 1); chk("t3_ovf", v, 1);
    chk("t3_zero", z, 1); chk("t3_latency", l, W + 1);

    run_op(4'b1001, 4'b1010, 0, 0, 3, r, c, v, z, l);
    chk("t4_result", r, 4'b0011); chk("t4_cout", c, 1); chk("t4_ovf", v, 1);

    run_op(4'b0010, 4'b0011, 0, 0, 0, r, c, v, z, l);
    chk("t5_add", r, 4'b0101);
    run_op(4'b0000, 4'b0100, 0, 1, 0, r, c, v, z, l);
    chk("t5_acc_add", r, 4'b1001); chk("t5_acc_ovf", v, 1);
    run_op(4'b0110, 4'b0111, 7, 0, 0, r, c, v, z, l);
    chk("t5_clr", r, 0); chk("t5_clr_zero", z, 1);
    run_op(4'b1111, 4'b0000, 0, 1, 0, r, c, v, z, l);
    chk("t5_acc_cleared", r, 0);

    a = 4'b1100; b = 4'b1000; op = 3'd6; use_acc = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t6_in_ready", in_ready, 1); chk("t6_out_valid", out_valid, 0);
    chk("t6_busy", busy, 0); chk("t6_result", result, 0);
    chk("t6_flags", {cout, overflow, zero}, 0);
    repeat (W + 3) @(negedge clk);
    chk("t6_no_stale", out_valid, 0);

    for (int i = 0; i < 3000; i++) begin
      in_valid  = 1'($urandom);
      a         = W'($urandom);
      b         = W'($urandom);
      op        = 3'($urandom);
      use_acc   = 1'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      rst       = ($urandom_range(0, 299) == 0);
      @(negedge clk);
    end
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (W + 3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
